// File: rtl/arp_tx_scheduler.sv
// ARP transmit scheduler: arbitrates a single-entry reply slot against a
// resolve tracker with retry timer, issuing one command per ARP frame.
module arp_tx_scheduler #(
  parameter logic [31:0] P_RETRY_CYCLES = 32'd156_250_000,
  parameter int unsigned P_MAX_RETRY    = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_reply_req,
  input  logic [47:0] i_reply_mac,
  input  logic [31:0] i_reply_ip,
  input  logic        i_resolve_req,
  input  logic [31:0] i_resolve_ip,
  input  logic        i_resolved_valid,
  input  logic [31:0] i_resolved_ip,
  input  logic        i_tx_last,
  output logic        o_arp_reply,
  output logic        o_recv_target_valid,
  output logic [47:0] o_recv_target_mac,
  output logic [31:0] o_recv_target_ip,
  output logic        o_arp_active,
  output logic [31:0] o_arp_active_dst_ip,
  output logic        o_resolve_busy,
  output logic        o_resolve_done,
  output logic        o_resolve_fail,
  output logic        o_reply_drop
);

  localparam int RW = (P_MAX_RETRY < 1) ? 1 : $clog2(P_MAX_RETRY + 1);

  typedef enum logic [0:0] {
    S_IDLE,
    S_WAIT_TX
  } state_t;

  state_t state_reg, state_next;
  logic   issue_reply, issue_req;

  logic        reply_full_reg;
  logic [47:0] reply_mac_reg;
  logic [31:0] reply_ip_reg;
  logic        reply_load, reply_drop;

  logic          busy_reg, due_reg, timer_run_reg, frame_is_req_reg;
  logic [31:0]   res_ip_reg;
  logic [31:0]   timer_reg;
  logic [RW-1:0] retry_cnt_reg;
  logic          done_reg, fail_reg;
  logic          accept, match, req_tx_done, expire;

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Command arbitration: a waiting reply always goes before a due request
  always_comb begin
    state_next  = state_reg;
    issue_reply = 1'b0;
    issue_req   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (reply_full_reg) begin
          issue_reply = 1'b1;
          state_next  = S_WAIT_TX;
        end else if (due_reg) begin
          issue_req  = 1'b1;
          state_next = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (i_tx_last) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A new reply may replace the entry that is leaving the slot this cycle
  assign reply_load = i_reply_req && (!reply_full_reg || issue_reply);
  assign reply_drop = i_reply_req && reply_full_reg && !issue_reply;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      reply_full_reg <= 1'b0;
      reply_mac_reg  <= '0;
      reply_ip_reg   <= '0;
    end else if (reply_load) begin
      reply_full_reg <= 1'b1;
      reply_mac_reg  <= i_reply_mac;
      reply_ip_reg   <= i_reply_ip;
    end else if (issue_reply) begin
      reply_full_reg <= 1'b0;
    end
  end

  assign accept      = i_resolve_req && !busy_reg;
  assign match       = busy_reg && i_resolved_valid && (i_resolved_ip == res_ip_reg);
  assign req_tx_done = (state_reg == S_WAIT_TX) && i_tx_last && frame_is_req_reg;
  assign expire      = busy_reg && timer_run_reg && (timer_reg == P_RETRY_CYCLES - 32'd1);

  // Resolve tracker; a match outranks a simultaneous timer expiry
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_reg      <= 1'b0;
      due_reg       <= 1'b0;
      timer_run_reg <= 1'b0;
      timer_reg     <= '0;
      retry_cnt_reg <= '0;
      res_ip_reg    <= '0;
      done_reg      <= 1'b0;
      fail_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      fail_reg <= 1'b0;
      if (accept) begin
        res_ip_reg    <= i_resolve_ip;
        retry_cnt_reg <= '0;
        busy_reg      <= 1'b1;
        due_reg       <= 1'b1;
        timer_run_reg <= 1'b0;
        timer_reg     <= '0;
      end else if (match) begin
        done_reg      <= 1'b1;
        busy_reg      <= 1'b0;
        due_reg       <= 1'b0;
        timer_run_reg <= 1'b0;
        timer_reg     <= '0;
      end else begin
        if (issue_req) begin
          due_reg <= 1'b0;
        end
        if (expire) begin
          timer_run_reg <= 1'b0;
          if (retry_cnt_reg == RW'(P_MAX_RETRY)) begin
            fail_reg <= 1'b1;
            busy_reg <= 1'b0;
          end else begin
            retry_cnt_reg <= retry_cnt_reg + RW'(1);
            due_reg       <= 1'b1;
          end
        end else if (req_tx_done && busy_reg) begin
          timer_reg     <= '0;
          timer_run_reg <= 1'b1;
        end else if (timer_run_reg) begin
          timer_reg <= timer_reg + 32'd1;
        end
      end
    end
  end

  // Remembers which kind of frame is in flight so only request frames arm the timer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_is_req_reg <= 1'b0;
    end else if (issue_reply || issue_req) begin
      frame_is_req_reg <= issue_req;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_arp_reply         <= 1'b0;
      o_recv_target_valid <= 1'b0;
      o_recv_target_mac   <= '0;
      o_recv_target_ip    <= '0;
      o_arp_active        <= 1'b0;
      o_arp_active_dst_ip <= '0;
      o_reply_drop        <= 1'b0;
    end else begin
      o_arp_reply         <= issue_reply;
      o_recv_target_valid <= issue_reply;
      o_recv_target_mac   <= issue_reply ? reply_mac_reg : 48'd0;
      o_recv_target_ip    <= issue_reply ? reply_ip_reg : 32'd0;
      o_arp_active        <= issue_req;
      o_arp_active_dst_ip <= issue_req ? res_ip_reg : 32'd0;
      o_reply_drop        <= reply_drop;
    end
  end

  assign o_resolve_busy = busy_reg;
  assign o_resolve_done = done_reg;
  assign o_resolve_fail = fail_reg;

endmodule

// File: tb/tb_arp_tx_scheduler.sv
// Directed bench for arp_tx_scheduler with a short retry interval.
module tb_arp_tx_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_reply_req;
  logic [47:0] i_reply_mac;
  logic [31:0] i_reply_ip;
  logic        i_resolve_req;
  logic [31:0] i_resolve_ip;
  logic        i_resolved_valid;
  logic [31:0] i_resolved_ip;
  logic        i_tx_last;
  logic        o_arp_reply;
  logic        o_recv_target_valid;
  logic [47:0] o_recv_target_mac;
  logic [31:0] o_recv_target_ip;
  logic        o_arp_active;
  logic [31:0] o_arp_active_dst_ip;
  logic        o_resolve_busy;
  logic        o_resolve_done;
  logic        o_resolve_fail;
  logic        o_reply_drop;

  int tests_run = 0;
  int tests_failed = 0;
  int n;
  logic got_active, got_fail;

  always #5 i_clk = ~i_clk;

  arp_tx_scheduler #(
    .P_RETRY_CYCLES(32'd10),
    .P_MAX_RETRY   (3)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_reply_req        (i_reply_req),
    .i_reply_mac        (i_reply_mac),
    .i_reply_ip         (i_reply_ip),
    .i_resolve_req      (i_resolve_req),
    .i_resolve_ip       (i_resolve_ip),
    .i_resolved_valid   (i_resolved_valid),
    .i_resolved_ip      (i_resolved_ip),
    .i_tx_last          (i_tx_last),
    .o_arp_reply        (o_arp_reply),
    .o_recv_target_valid(o_recv_target_valid),
    .o_recv_target_mac  (o_recv_target_mac),
    .o_recv_target_ip   (o_recv_target_ip),
    .o_arp_active       (o_arp_active),
    .o_arp_active_dst_ip(o_arp_active_dst_ip),
    .o_resolve_busy     (o_resolve_busy),
    .o_resolve_done     (o_resolve_done),
    .o_resolve_fail     (o_resolve_fail),
    .o_reply_drop       (o_reply_drop)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs cycles and requires that no reply or request command appears
  task automatic no_cmd(input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      seen = seen | o_arp_reply | o_arp_active;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  task automatic tx_last_pulse();
    i_tx_last = 1'b1;
    tick();
    i_tx_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    i_reply_req = 1'b0; i_reply_mac = '0; i_reply_ip = '0;
    i_resolve_req = 1'b0; i_resolve_ip = '0;
    i_resolved_valid = 1'b0; i_resolved_ip = '0;
    i_tx_last = 1'b0;
    tick(); tick(); tick();
    chk("rst_reply", 64'(o_arp_reply), 64'd0);
    chk("rst_active", 64'(o_arp_active), 64'd0);
    chk("rst_busy", 64'(o_resolve_busy), 64'd0);
    chk("rst_drop", 64'(o_reply_drop), 64'd0);
    chk("rst_mac", 64'(o_recv_target_mac), 64'd0);
    i_rst = 1'b0;
    tick();

    // Single reply: pulse two edges after the request, then silence until tx_last
    i_reply_req = 1'b1; i_reply_mac = 48'h0A0B0C0D0E0F; i_reply_ip = 32'hC0A86401;
    tick();
    i_reply_req = 1'b0;
    chk("r27_not_yet", 64'(o_arp_reply), 64'd0);
    tick();
    chk("r27_reply", 64'(o_arp_reply), 64'd1);
    chk("r27_valid", 64'(o_recv_target_valid), 64'd1);
    chk("r27_mac", 64'(o_recv_target_mac), 64'h0A0B0C0D0E0F);
    chk("r27_ip", 64'(o_recv_target_ip), 64'hC0A86401);
    chk("r27_no_active", 64'(o_arp_active), 64'd0);
    tick();
    chk("r27_one_pulse", 64'(o_arp_reply), 64'd0);
    no_cmd(5, "r27_hold");
    tx_last_pulse();
    no_cmd(5, "r27_after_last");

    // Reply and resolve together: reply first, request after reply frame ends
    i_reply_req = 1'b1; i_reply_mac = 48'h112233445566; i_reply_ip = 32'hC0A86402;
    i_resolve_req = 1'b1; i_resolve_ip = 32'hC0A86407;
    tick();
    i_reply_req = 1'b0; i_resolve_req = 1'b0;
    chk("r28_busy", 64'(o_resolve_busy), 64'd1);
    tick();
    chk("r28_reply_first", 64'(o_arp_reply), 64'd1);
    chk("r28_req_waits", 64'(o_arp_active), 64'd0);
    no_cmd(3, "r28_hold");
    tx_last_pulse();
    chk("r28_idle_cycle", 64'(o_arp_active), 64'd0);
    tick();
    chk("r28_active", 64'(o_arp_active), 64'd1);
    chk("r28_dst", 64'(o_arp_active_dst_ip), 64'hC0A86407);
    chk("r28_no_reply", 64'(o_arp_reply), 64'd0);
    tick();
    chk("r28_active_pulse", 64'(o_arp_active), 64'd0);
    tx_last_pulse();
    tick();
    i_resolved_valid = 1'b1; i_resolved_ip = 32'hC0A86407;
    tick();
    i_resolved_valid = 1'b0;
    chk("r28_done", 64'(o_resolve_done), 64'd1);
    chk("r28_busy_clr", 64'(o_resolve_busy), 64'd0);
    tick();
    chk("r28_done_pulse", 64'(o_resolve_done), 64'd0);
    no_cmd(15, "r28_no_retry");

    // No answer: four request frames 11 edges apart, then fail 10 edges after the last
    i_resolve_req = 1'b1; i_resolve_ip = 32'hC0A80A0A;
    tick();
    i_resolve_req = 1'b0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("r29_frame%0d_active", k), 64'(o_arp_active), 64'd1);
      chk($sformatf("r29_frame%0d_dst", k), 64'(o_arp_active_dst_ip), 64'hC0A80A0A);
      tick(); tick();
      tx_last_pulse();
      n = 0; got_active = 1'b0; got_fail = 1'b0;
      while (n < 30 && !got_active && !got_fail) begin
        tick();
        n++;
        got_active = o_arp_active;
        got_fail = o_resolve_fail;
      end
      if (k < 4) begin
        chk($sformatf("r29_retry%0d_gap", k), 64'(n), 64'd11);
      end else begin
        chk("r29_fail_gap", 64'(n), 64'd10);
        chk("r29_fail", 64'(o_resolve_fail), 64'd1);
        chk("r29_no_5th", 64'(o_arp_active), 64'd0);
        chk("r29_busy_low", 64'(o_resolve_busy), 64'd0);
      end
    end
    tick();
    chk("r29_fail_pulse", 64'(o_resolve_fail), 64'd0);
    no_cmd(30, "r29_quiet");

    // Match in the same cycle as expiry wins; a wrong IP beforehand is ignored
    i_resolve_req = 1'b1; i_resolve_ip = 32'hC0A81E1E;
    tick();
    i_resolve_req = 1'b0;
    tick();
    chk("r30_active", 64'(o_arp_active), 64'd1);
    tick();
    tx_last_pulse();
    tick(); tick(); tick();
    i_resolved_valid = 1'b1; i_resolved_ip = 32'hC0A81E1F;
    tick();
    i_resolved_valid = 1'b0;
    chk("r30_wrong_ip_busy", 64'(o_resolve_busy), 64'd1);
    chk("r30_wrong_ip_done", 64'(o_resolve_done), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    i_resolved_valid = 1'b1; i_resolved_ip = 32'hC0A81E1E;
    tick();
    i_resolved_valid = 1'b0;
    chk("r30_done", 64'(o_resolve_done), 64'd1);
    chk("r30_no_fail", 64'(o_resolve_fail), 64'd0);
    chk("r30_busy_clr", 64'(o_resolve_busy), 64'd0);
    no_cmd(20, "r30_no_retry");

    // Two replies during WAIT_TX: first is held, second dropped
    i_reply_req = 1'b1; i_reply_mac = 48'hAAAAAAAAAAAA; i_reply_ip = 32'h0A000001;
    tick();
    i_reply_req = 1'b0;
    tick();
    chk("r31_first_frame", 64'(o_arp_reply), 64'd1);
    i_reply_req = 1'b1; i_reply_mac = 48'hBBBBBBBBBBBB; i_reply_ip = 32'h0A000002;
    tick();
    chk("r31_b_no_drop", 64'(o_reply_drop), 64'd0);
    i_reply_mac = 48'hCCCCCCCCCCCC; i_reply_ip = 32'h0A000003;
    tick();
    i_reply_req = 1'b0;
    chk("r31_c_drop", 64'(o_reply_drop), 64'd1);
    tick();
    chk("r31_drop_pulse", 64'(o_reply_drop), 64'd0);
    no_cmd(2, "r31_hold");
    tx_last_pulse();
    tick();
    chk("r31_b_reply", 64'(o_arp_reply), 64'd1);
    chk("r31_b_mac", 64'(o_recv_target_mac), 64'hBBBBBBBBBBBB);
    chk("r31_b_ip", 64'(o_recv_target_ip), 64'h0A000002);
    tick();
    tx_last_pulse();
    no_cmd(5, "r31_c_gone");

    // Reset while in WAIT_TX with a request due abandons everything
    i_reply_req = 1'b1; i_reply_mac = 48'hDDDDDDDDDDDD; i_reply_ip = 32'h0A000004;
    i_resolve_req = 1'b1; i_resolve_ip = 32'hC0A80505;
    tick();
    i_reply_req = 1'b0; i_resolve_req = 1'b0;
    tick();
    chk("r32_reply", 64'(o_arp_reply), 64'd1);
    i_rst = 1'b1;
    #1;
    chk("r32_async_reply", 64'(o_arp_reply), 64'd0);
    chk("r32_async_valid", 64'(o_recv_target_valid), 64'd0);
    chk("r32_async_busy", 64'(o_resolve_busy), 64'd0);
    tick(); tick();
    i_rst = 1'b0;
    no_cmd(30, "r32_no_cmd");
    chk("r32_busy_low", 64'(o_resolve_busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
